// File: rtl/dense_output_collector_pkg.sv
// Shared types and helpers for the dense-layer output collector.
// Holds the collector state encoding, default sizes and the saturation helper.
package dense_collect_pkg;

    localparam int N_NEURONS_DEF = 128;
    localparam int DATA_W_DEF    = 32;
    localparam int OUT_W_DEF     = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        DONE
    } state_e;

    // Clamp v into the signed out_w-bit range; clamped reports whether a limit was hit.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int out_w,
                                                    output logic clamped);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (out_w - 1));
        clamped = 1'b0;
        saturate = v;
        if (v > hi) begin
            saturate = hi;
            clamped  = 1'b1;
        end else if (v < lo) begin
            saturate = lo;
            clamped  = 1'b1;
        end
    endfunction

endpackage

// File: rtl/dense_output_collector_if.sv
// Registered result read port of the collector, as seen from the OCL AXI-Lite slave.
interface dense_output_collector_if
    import dense_collect_pkg::*;
#(
    parameter int IDX_W = $clog2(N_NEURONS_DEF),
    parameter int OUT_W = OUT_W_DEF
);
    logic                    rd_en;
    logic [IDX_W-1:0]        rd_addr;
    logic signed [OUT_W-1:0] rd_data;
    logic                    rd_valid;

    modport master (output rd_en, output rd_addr, input rd_data, input rd_valid);
    modport slave  (input rd_en, input rd_addr, output rd_data, output rd_valid);
endinterface

// File: rtl/dense_output_collector_requant.sv
// Stage 1 of the collector pipeline: optional ReLU then arithmetic right shift,
// registered together with a valid strobe.
module dense_requant_unit
    import dense_collect_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk_main_a0,
    input  logic                     rst_main_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     relu_en,
    input  logic [4:0]               shift_amt,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data
);

    logic signed [DATA_W-1:0] relu_val;

    always_comb begin
        relu_val = (relu_en && in_data[DATA_W-1]) ? '0 : in_data;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= relu_val >>> shift_amt;
            end
        end
    end

endmodule

// File: rtl/dense_output_collector.sv
// Collects N neuron outputs after all cores finish, requantises them into a result
// buffer with running argmax/saturation statistics, and serves registered reads.
module dense_output_collector
    import dense_collect_pkg::*;
#(
    parameter int N_NEURONS = N_NEURONS_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic                        clk_main_a0,
    input  logic                        rst_main_n,
    input  logic                        start,
    input  logic                        relu_en,
    input  logic [4:0]                  shift_amt,
    input  logic [N_NEURONS-1:0]        neuron_done,
    input  logic [N_NEURONS*DATA_W-1:0] neuron_data,
    dense_output_collector_if.slave     rd_if,
    output logic                        busy,
    output logic                        done,
    output logic [IDX_W-1:0]            argmax_idx,
    output logic signed [OUT_W-1:0]     argmax_val,
    output logic [IDX_W:0]              sat_count
);

    localparam logic [IDX_W:0]   N_CNT    = (IDX_W + 1)'(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_e state_q, state_d;

    logic                     start_acc;
    logic                     cfg_relu;
    logic [4:0]               cfg_shift;
    logic [IDX_W:0]           sel_cnt;
    logic                     sel_valid;
    logic [IDX_W-1:0]         sel_idx;
    logic signed [DATA_W-1:0] sel_data;
    logic [IDX_W-1:0]         s1_idx;
    logic                     s1_valid;
    logic signed [DATA_W-1:0] s1_data;
    logic signed [OUT_W-1:0]  s2_res;
    logic                     s2_clamp;
    logic                     result_valid;

    logic signed [OUT_W-1:0]  result_mem [N_NEURONS];

    assign start_acc    = start && (state_q == IDLE || state_q == DONE);
    assign sel_valid    = (state_q == RUN) && (sel_cnt < N_CNT);
    assign sel_idx      = sel_cnt[IDX_W-1:0];
    assign sel_data     = neuron_data[sel_idx*DATA_W +: DATA_W];
    assign result_valid = (state_q == DONE);
    assign busy         = (state_q == ARMED) || (state_q == RUN);
    assign done         = (state_q == DONE);

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: assigning state_d before the case keeps this block free of latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = ARMED;
            ARMED:      if (&neuron_done) state_d = RUN;
            RUN:        if (s1_valid && s1_idx == LAST_IDX) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    dense_requant_unit #(.DATA_W(DATA_W)) u_requant (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .in_valid    (sel_valid),
        .in_data     (sel_data),
        .relu_en     (cfg_relu),
        .shift_amt   (cfg_shift),
        .out_valid   (s1_valid),
        .out_data    (s1_data)
    );

    always_comb begin
        s2_clamp = 1'b0;
        s2_res   = OUT_W'(saturate(64'(s1_data), OUT_W, s2_clamp));
    end

    // NOTE: the result buffer has no reset; result_valid gates every read of stale data.
    always_ff @(posedge clk_main_a0) begin
        if (s1_valid) begin
            result_mem[s1_idx] <= s2_res;
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            cfg_relu         <= 1'b0;
            cfg_shift        <= '0;
            sel_cnt          <= '0;
            s1_idx           <= '0;
            argmax_idx       <= '0;
            argmax_val       <= '0;
            sat_count        <= '0;
            rd_if.rd_valid   <= 1'b0;
            rd_if.rd_data    <= '0;
        end else begin
            if (start_acc) begin
                cfg_relu   <= relu_en;
                cfg_shift  <= shift_amt;
                sel_cnt    <= '0;
                argmax_idx <= '0;
                argmax_val <= '0;
                sat_count  <= '0;
            end
            if (sel_valid) begin
                sel_cnt <= sel_cnt + 1'b1;
                s1_idx  <= sel_idx;
            end
            // Element 0 seeds argmax; later elements replace it only when strictly greater.
            if (s1_valid) begin
                if (s2_clamp) sat_count <= sat_count + 1'b1;
                if (s1_idx == '0 || s2_res > argmax_val) begin
                    argmax_idx <= s1_idx;
                    argmax_val <= s2_res;
                end
            end
            rd_if.rd_valid <= rd_if.rd_en;
            if (rd_if.rd_en && result_valid && ({1'b0, rd_if.rd_addr} < N_CNT)) begin
                rd_if.rd_data <= result_mem[rd_if.rd_addr];
            end else begin
                rd_if.rd_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dense_output_collector.sv
// Directed bench for dense_output_collector: table of full-run scenarios plus
// hand-written sequences for ARMED hold, ignored restart and reset mid-run.
module tb_dense_output_collector;
    import dense_collect_pkg::*;

    localparam int N     = 128;
    localparam int DW    = 32;
    localparam int OW    = 16;
    localparam int IW    = 7;
    localparam int LAT   = 130;

    logic            clk_main_a0 = 1'b0;
    logic            rst_main_n  = 1'b0;
    logic            start       = 1'b0;
    logic            relu_en     = 1'b0;
    logic [4:0]      shift_amt   = '0;
    logic [N-1:0]    neuron_done = '0;
    logic [N*DW-1:0] neuron_data = '0;
    logic            busy;
    logic            done;
    logic [IW-1:0]   argmax_idx;
    logic signed [OW-1:0] argmax_val;
    logic [IW:0]     sat_count;

    dense_output_collector_if #(.IDX_W(IW), .OUT_W(OW)) rd_if ();

    dense_output_collector dut (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .start       (start),
        .relu_en     (relu_en),
        .shift_amt   (shift_amt),
        .neuron_done (neuron_done),
        .neuron_data (neuron_data),
        .rd_if       (rd_if),
        .busy        (busy),
        .done        (done),
        .argmax_idx  (argmax_idx),
        .argmax_val  (argmax_val),
        .sat_count   (sat_count)
    );

    always #5 clk_main_a0 = ~clk_main_a0;

    int errors = 0;
    int checks = 0;
    int nval [N];
    int got  [N];
    int done_rises = 0;
    logic done_d = 1'b0;

    always @(negedge clk_main_a0) begin
        done_d <= done;
        if (done && !done_d) done_rises <= done_rises + 1;
    end

    typedef struct {
        int pat;
        bit relu;
        int sh;
        int a_addr;
        int a_val;
        int b_addr;
        int b_val;
        int amax_idx;
        int amax_val;
        int sat;
    } scen_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_main_a0);
        #1;
    endtask

    // Reference requantiser: floor division by 2^sh, then clamp to 16-bit signed.
    function automatic int model_val(input int x, input bit relu, input int sh);
        longint v;
        longint p;
        v = x;
        if (relu && v < 0) v = 0;
        p = longint'(1) << sh;
        if (v >= 0) v = v / p;
        else        v = -((-v + p - 1) / p);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return int'(v);
    endfunction

    task automatic fill(input int pat);
        for (int i = 0; i < N; i++) begin
            case (pat)
                0: nval[i] = 65;
                1: nval[i] = i - 64;
                2: nval[i] = (i == 0) ? -7 : (i == 5) ? 32'h0001_0000 : 0;
                3: nval[i] = (i == 0) ? -7 : (i == 5) ? -32'sh0004_0000 : 0;
                default: nval[i] = (i - 64) * 1000;
            endcase
            neuron_data[i*DW +: DW] = nval[i];
        end
    endtask

    // Pulse start, then count edges until done; optionally disturb start/config mid-run.
    task automatic run(input bit relu, input int sh, input int disturb_at, output int lat);
        relu_en   = relu;
        shift_amt = 5'(sh);
        start     = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 400) begin
            tick();
            lat++;
            if (lat == disturb_at) begin
                start     = 1'b1;
                relu_en   = ~relu;
                shift_amt = 5'd5;
            end else if (lat == disturb_at + 1) begin
                start = 1'b0;
            end
        end
        start   = 1'b0;
        relu_en = relu;
    endtask

    task automatic read_one(input int addr, output int data, output bit valid);
        rd_if.rd_en   = 1'b1;
        rd_if.rd_addr = IW'(addr);
        tick();
        rd_if.rd_en = 1'b0;
        data  = int'(rd_if.rd_data);
        valid = rd_if.rd_valid;
    endtask

    task automatic read_all(input string tag);
        int nbad;
        nbad = 0;
        rd_if.rd_en   = 1'b1;
        rd_if.rd_addr = '0;
        for (int a = 0; a < N; a++) begin
            tick();
            if (rd_if.rd_valid !== 1'b1) nbad++;
            got[a] = int'(rd_if.rd_data);
            if (a < N - 1) rd_if.rd_addr = IW'(a + 1);
            else           rd_if.rd_en   = 1'b0;
        end
        tick();
        check({tag, " rd_valid burst misses"}, nbad, 0);
        check({tag, " rd_valid drops"}, rd_if.rd_valid, 0);
    endtask

    task automatic compare_model(input string tag, input bit relu, input int sh);
        for (int a = 0; a < N; a++)
            check($sformatf("%s rd[%0d]", tag, a), got[a], model_val(nval[a], relu, sh));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        scen_t scen [5];
        int lat;
        int d;
        bit v;
        int snap;

        scen[0] = '{0, 1'b1, 0,   0,     65, 127,     65,   0,    65, 0};
        scen[1] = '{1, 1'b1, 0,  64,      0,  65,      1, 127,    63, 0};
        scen[2] = '{2, 1'b0, 1,   0,     -4,   5,  32767,   5, 32767, 1};
        scen[3] = '{3, 1'b0, 1,   0,     -4,   5, -32768,   1,     0, 1};
        scen[4] = '{4, 1'b0, 3,   0,  -8000, 127,   7875, 127,  7875, 0};

        rd_if.rd_en   = 1'b0;
        rd_if.rd_addr = '0;
        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset argmax_idx", argmax_idx, 0);
        check("reset argmax_val", argmax_val, 0);
        check("reset sat_count", sat_count, 0);
        check("reset rd_valid", rd_if.rd_valid, 0);
        check("reset rd_data", rd_if.rd_data, 0);
        rst_main_n = 1'b1;
        tick();

        neuron_done = '1;
        for (int k = 0; k < 5; k++) begin
            string tag;
            tag = $sformatf("s%0d", k);
            fill(scen[k].pat);
            run(scen[k].relu, scen[k].sh, -1, lat);
            check({tag, " done latency"}, lat, LAT);
            check({tag, " busy at done"}, busy, 0);
            check({tag, " argmax_idx"}, argmax_idx, scen[k].amax_idx);
            check({tag, " argmax_val"}, argmax_val, scen[k].amax_val);
            check({tag, " sat_count"}, sat_count, scen[k].sat);
            read_all(tag);
            check({tag, " point a"}, got[scen[k].a_addr], scen[k].a_val);
            check({tag, " point b"}, got[scen[k].b_addr], scen[k].b_val);
            compare_model(tag, scen[k].relu, scen[k].sh);
        end

        // ARMED hold: neuron_done low keeps the block waiting with reads returning 0.
        neuron_done = '0;
        fill(1);
        relu_en   = 1'b1;
        shift_amt = '0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        d = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) d++;
            tick();
        end
        check("armed busy/done hold", d, 0);
        read_one(0, d, v);
        check("armed rd[0] data", d, 0);
        check("armed rd[0] valid", v, 1);
        read_one(127, d, v);
        check("armed rd[127] data", d, 0);
        neuron_done = '1;
        lat = 0;
        while (!done && lat < 400) begin
            tick();
            lat++;
        end
        check("armed done latency", lat, LAT);
        read_all("armed");
        compare_model("armed", 1'b1, 0);

        // Restart pulse and config change during RUN must be ignored.
        snap = done_rises;
        fill(1);
        run(1'b1, 0, 10, lat);
        check("restart done latency", lat, LAT);
        repeat (20) tick();
        check("restart done rises", done_rises - snap, 1);
        check("restart done held", done, 1);
        check("restart argmax_idx", argmax_idx, 127);
        check("restart argmax_val", argmax_val, 63);
        read_all("restart");
        compare_model("restart", 1'b1, 0);

        // Reset while element 40 is being selected, then a clean rerun.
        fill(4);
        relu_en   = 1'b0;
        shift_amt = 5'd3;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (41) tick();
        check("pre-reset busy", busy, 1);
        rst_main_n = 1'b0;
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst rd_data", rd_if.rd_data, 0);
        check("midrst argmax_val", argmax_val, 0);
        check("midrst sat_count", sat_count, 0);
        tick();
        tick();
        rst_main_n = 1'b1;
        repeat (5) tick();
        check("post-reset idle busy", busy, 0);
        read_one(10, d, v);
        check("post-reset rd_data", d, 0);
        run(1'b0, 3, -1, lat);
        check("rerun done latency", lat, LAT);
        check("rerun argmax_idx", argmax_idx, 127);
        check("rerun argmax_val", argmax_val, 7875);
        check("rerun sat_count", sat_count, 0);
        read_all("rerun");
        compare_model("rerun", 1'b0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
